// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver with a 2-flop input synchroniser and mid-bit sampling.
// Define UART_RX_FRAME_ERR_EN to add o_RX_Err and suppress delivery on a bad stop bit.
module uart_rx #(
  parameter int CLKS_PER_BIT = 217
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_RX_Serial,
  output logic       o_RX_DV,
`ifdef UART_RX_FRAME_ERR_EN
  output logic       o_RX_Err,
`endif
  output logic [7:0] o_RX_Byte
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] HALF = CNT_W'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_START   = 3'd1,
    S_DATA    = 3'd2,
    S_STOP    = 3'd3,
    S_CLEANUP = 3'd4
  } state_t;

  state_t           r_state;
  state_t           w_next_state;
  logic             r_rx_meta;
  logic             r_rx_s;
  logic [CNT_W-1:0] r_clk_cnt;
  logic [CNT_W-1:0] w_clk_cnt_nxt;
  logic [2:0]       r_bit_idx;
  logic [2:0]       w_bit_idx_nxt;
  logic [7:0]       r_shift;
  logic [7:0]       w_shift_nxt;
  logic             r_dv;
  logic [7:0]       r_byte;
  logic             w_dv_set;
  logic             w_err_set;
  logic             w_cnt_half;
  logic             w_cnt_last;

  // Both flops reset high so a reset never looks like a start edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rx_meta <= 1'b1;
      r_rx_s    <= 1'b1;
    end else begin
      r_rx_meta <= i_RX_Serial;
      r_rx_s    <= r_rx_meta;
    end
  end

  assign w_cnt_half = (r_clk_cnt == HALF);
  assign w_cnt_last = (r_clk_cnt == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (!r_rx_s) w_next_state = S_START;
      end
      S_START: begin
        if (w_cnt_half) w_next_state = r_rx_s ? S_IDLE : S_DATA;
      end
      S_DATA: begin
        if (w_cnt_last && (r_bit_idx == 3'd7)) w_next_state = S_STOP;
      end
      S_STOP: begin
        if (w_cnt_last) w_next_state = S_CLEANUP;
      end
      S_CLEANUP: begin
`ifdef UART_RX_FRAME_ERR_EN
        // After a framing error the line may still be low; wait for it to idle.
        if (r_rx_s) w_next_state = S_IDLE;
`else
        w_next_state = S_IDLE;
`endif
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  always_comb begin
    w_clk_cnt_nxt = '0;
    w_bit_idx_nxt = r_bit_idx;
    w_shift_nxt   = r_shift;
    w_dv_set      = 1'b0;
    w_err_set     = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_bit_idx_nxt = '0;
      end
      S_START: begin
        if (!w_cnt_half) w_clk_cnt_nxt = r_clk_cnt + 1'b1;
      end
      S_DATA: begin
        if (w_cnt_last) begin
          w_shift_nxt[r_bit_idx] = r_rx_s;
          w_bit_idx_nxt          = r_bit_idx + 1'b1;
        end else begin
          w_clk_cnt_nxt = r_clk_cnt + 1'b1;
        end
      end
      S_STOP: begin
        if (w_cnt_last) begin
`ifdef UART_RX_FRAME_ERR_EN
          w_dv_set  = r_rx_s;
          w_err_set = !r_rx_s;
`else
          w_dv_set  = 1'b1;
`endif
        end else begin
          w_clk_cnt_nxt = r_clk_cnt + 1'b1;
        end
      end
      default: begin
        w_bit_idx_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_clk_cnt <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
      r_dv      <= 1'b0;
      r_byte    <= '0;
    end else begin
      r_clk_cnt <= w_clk_cnt_nxt;
      r_bit_idx <= w_bit_idx_nxt;
      r_shift   <= w_shift_nxt;
      r_dv      <= w_dv_set;
      if (w_dv_set) r_byte <= r_shift;
    end
  end

`ifdef UART_RX_FRAME_ERR_EN
  logic r_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err <= 1'b0;
    end else begin
      r_err <= w_err_set;
    end
  end

  assign o_RX_Err = r_err;
`else
  logic w_err_unused;
  assign w_err_unused = w_err_set;
`endif

  assign o_RX_DV   = r_dv;
  assign o_RX_Byte = r_byte;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: two instances (217 clk/bit @ 40 ns, 434 clk/bit @ 20 ns)
// share one serial line; both have the same 8680 ns bit period.
`timescale 1ns/1ps
module tb_uart_rx;
  localparam int BIT_NS = 8680;

  logic       clk  = 1'b0;
  logic       clk2 = 1'b0;
  logic       rst  = 1'b1;
  logic       rx   = 1'b1;
  logic       dv1, dv2;
  logic [7:0] byte1, byte2;
`ifdef UART_RX_FRAME_ERR_EN
  logic       err1, err2;
`endif

  always #20 clk  = ~clk;
  always #10 clk2 = ~clk2;

  uart_rx #(.CLKS_PER_BIT(217)) u_dut (
    .clk         (clk),
    .rst         (rst),
    .i_RX_Serial (rx),
    .o_RX_DV     (dv1),
`ifdef UART_RX_FRAME_ERR_EN
    .o_RX_Err    (err1),
`endif
    .o_RX_Byte   (byte1)
  );

  uart_rx #(.CLKS_PER_BIT(434)) u_dut434 (
    .clk         (clk2),
    .rst         (rst),
    .i_RX_Serial (rx),
    .o_RX_DV     (dv2),
`ifdef UART_RX_FRAME_ERR_EN
    .o_RX_Err    (err2),
`endif
    .o_RX_Byte   (byte2)
  );

  int total = 0;
  int bad   = 0;

  int         dv_cnt1 = 0, dv_cnt2 = 0;
  int         dbl1 = 0, dbl2 = 0;
  int         err_cnt1 = 0, err_cnt2 = 0;
  logic       prev1 = 1'b0, prev2 = 1'b0;
  logic [7:0] log1 [0:31];
  logic [7:0] log2 [0:31];

  always @(negedge clk) begin
    if (dv1) begin
      if (dv_cnt1 < 32) log1[dv_cnt1] <= byte1;
      dv_cnt1 <= dv_cnt1 + 1;
      if (prev1) dbl1 <= dbl1 + 1;
    end
    prev1 <= dv1;
`ifdef UART_RX_FRAME_ERR_EN
    if (err1) err_cnt1 <= err_cnt1 + 1;
`endif
  end

  always @(negedge clk2) begin
    if (dv2) begin
      if (dv_cnt2 < 32) log2[dv_cnt2] <= byte2;
      dv_cnt2 <= dv_cnt2 + 1;
      if (prev2) dbl2 <= dbl2 + 1;
    end
    prev2 <= dv2;
`ifdef UART_RX_FRAME_ERR_EN
    if (err2) err_cnt2 <= err_cnt2 + 1;
`endif
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input int start_extra_ns, input logic stop_bit);
    rx = 1'b0;
    #(BIT_NS + start_extra_ns);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      #(BIT_NS);
    end
    rx = stop_bit;
    #(BIT_NS);
    rx = 1'b1;
  endtask

  int         b1, b2;
  logic [7:0] exp_after_stop0;

  initial begin
    // Reset state
    repeat (5) @(posedge clk);
    #1;
    chk("rst_dv1",   dv1,   0);
    chk("rst_byte1", byte1, 8'h00);
    chk("rst_dv2",   dv2,   0);
    chk("rst_byte2", byte2, 8'h00);
`ifdef UART_RX_FRAME_ERR_EN
    chk("rst_err1",  err1,  0);
`endif
    @(negedge clk);
    rst = 1'b0;
    #(BIT_NS);

    // T1: 0x37 with start bit stretched by 1000 ns
    b1 = dv_cnt1; b2 = dv_cnt2;
    send_frame(8'h37, 1000, 1'b1);
    #(BIT_NS);
    chk("t1_dv_count",  dv_cnt1 - b1, 1);
    chk("t1_dv_byte",   log1[b1],     8'h37);
    chk("t1_byte_hold", byte1,        8'h37);
    chk("t1_single",    dbl1,         0);
    chk("t1_byte_434",  log2[b2],     8'h37);

    // T2: back-to-back 00, FF, A5
    b1 = dv_cnt1; b2 = dv_cnt2;
    send_frame(8'h00, 0, 1'b1);
    send_frame(8'hFF, 0, 1'b1);
    send_frame(8'hA5, 0, 1'b1);
    #(BIT_NS);
    chk("t2_dv_count", dv_cnt1 - b1, 3);
    chk("t2_byte0",    log1[b1],     8'h00);
    chk("t2_byte1",    log1[b1 + 1], 8'hFF);
    chk("t2_byte2",    log1[b1 + 2], 8'hA5);
    chk("t2_single",   dbl1,         0);
    chk("t2_cnt_434",  dv_cnt2 - b2, 3);
    chk("t2_last_434", byte2,        8'hA5);

    // T3: 2000 ns glitch on an idle line
    b1 = dv_cnt1; b2 = dv_cnt2;
    rx = 1'b0;
    #2000;
    rx = 1'b1;
    #(BIT_NS * 3);
    chk("t3_no_dv",      dv_cnt1 - b1, 0);
    chk("t3_byte_kept",  byte1,        8'hA5);
    chk("t3_no_dv_434",  dv_cnt2 - b2, 0);

    // T5: 0x81 with a low stop bit
    b1 = dv_cnt1; b2 = dv_cnt2;
    send_frame(8'h81, 0, 1'b0);
    #(BIT_NS);
`ifdef UART_RX_FRAME_ERR_EN
    exp_after_stop0 = 8'hA5;
    chk("t5_err_pulse",  err_cnt1,     1);
    chk("t5_no_dv",      dv_cnt1 - b1, 0);
    chk("t5_err_434",    err_cnt2,     1);
`else
    exp_after_stop0 = 8'h81;
    chk("t5_dv_count",   dv_cnt1 - b1, 1);
    chk("t5_dv_434",     dv_cnt2 - b2, 1);
`endif
    chk("t5_byte",      byte1, exp_after_stop0);
    chk("t5_byte_434",  byte2, exp_after_stop0);
    #(BIT_NS);

    // T4: reset during data bit 4 of 0x5A, held to end of frame, then 0x3C
    b1 = dv_cnt1; b2 = dv_cnt2;
    fork
      send_frame(8'h5A, 0, 1'b1);
      begin
        #(BIT_NS * 5 + BIT_NS / 2);
        rst = 1'b1;
        #100;
        chk("t4_rst_dv1",   dv1,   0);
        chk("t4_rst_byte1", byte1, 8'h00);
        chk("t4_rst_byte2", byte2, 8'h00);
      end
    join
    chk("t4_no_dv_rst", dv_cnt1 - b1, 0);
    @(negedge clk);
    rst = 1'b0;
    #(BIT_NS);
    send_frame(8'h3C, 0, 1'b1);
    #(BIT_NS);
    chk("t4_dv_count", dv_cnt1 - b1, 1);
    chk("t4_byte",     log1[b1],     8'h3C);
    chk("t4_byte_434", byte2,        8'h3C);

    // T6: 434 clk/bit instance receives 0xC3
    b1 = dv_cnt1; b2 = dv_cnt2;
    send_frame(8'hC3, 0, 1'b1);
    #(BIT_NS);
    chk("t6_dv_count", dv_cnt2 - b2, 1);
    chk("t6_byte",     byte2,        8'hC3);
    chk("t6_single",   dbl2,         0);
    chk("t6_byte_217", byte1,        8'hC3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
